// File: rtl/cu_pipe_if.sv
// -----------------------------------------------------------------------------
// cu_pipe_if
// Bundle that links the ID stage, the control-unit decode FIFO (cu_pipe) and
// the ID/EX register.
//   ID side   : id_valid_i, id_ready_o, id_opcode_i, id_func3_i, id_func7_i
//   EX side   : ex_ready_i, ex_flush_i
//   CU outputs: cu_valid_o, cu_ALUctrl_o, cu_branch_o, cu_jump_o, cu_mem_o,
//               cu_illegal_o, cu_illegal_cnt_o
// The slave modport is the control unit's view of the bundle. The master
// modport is the view of whatever drives instructions in and takes decoded
// entries out.
// -----------------------------------------------------------------------------
interface cu_pipe_if #(
   parameter int ALUCTRL_W = 5,
   parameter int CNT_W     = 8
);
   logic                 id_valid_i;
   logic                 id_ready_o;
   logic [6:0]           id_opcode_i;
   logic [2:0]           id_func3_i;
   logic [6:0]           id_func7_i;
   logic                 ex_ready_i;
   logic                 ex_flush_i;
   logic                 cu_valid_o;
   logic [ALUCTRL_W-1:0] cu_ALUctrl_o;
   logic                 cu_branch_o;
   logic                 cu_jump_o;
   logic                 cu_mem_o;
   logic                 cu_illegal_o;
   logic [CNT_W-1:0]     cu_illegal_cnt_o;

   modport slave (
      input  id_valid_i, id_opcode_i, id_func3_i, id_func7_i,
      input  ex_ready_i, ex_flush_i,
      output id_ready_o, cu_valid_o, cu_ALUctrl_o, cu_branch_o, cu_jump_o,
      output cu_mem_o, cu_illegal_o, cu_illegal_cnt_o
   );

   modport master (
      output id_valid_i, id_opcode_i, id_func3_i, id_func7_i,
      output ex_ready_i, ex_flush_i,
      input  id_ready_o, cu_valid_o, cu_ALUctrl_o, cu_branch_o, cu_jump_o,
      input  cu_mem_o, cu_illegal_o, cu_illegal_cnt_o
   );
endinterface

// File: rtl/cu_pipe.sv
// -----------------------------------------------------------------------------
// cu_pipe
// Pipelined RV32I control-unit decoder. It decodes opcode/func3/func7 into an
// ALU control code, class flags (branch, jump, mem) and an illegal flag. The
// decoded entries are queued in a DEPTH-entry FIFO between ID and ID/EX.
// Ports:
//   clk   - clock
//   rst_n - asynchronous active-low reset
//   bus   - cu_pipe_if.slave: ID handshake and fields, EX ready/flush,
//           head-entry outputs and the saturating illegal-instruction count
// Parameters: ALUCTRL_W (>= 5), DEPTH (power of two, >= 2), CNT_W.
// Optional feature: define CU_M_EXT_EN to decode RV32M (R-type with
// func7=0000001) into ALU codes 16..23. Without it those encodings are illegal.
// -----------------------------------------------------------------------------
module cu_pipe #(
   parameter int ALUCTRL_W = 5,
   parameter int DEPTH     = 2,
   parameter int CNT_W     = 8
) (
   input  logic    clk,
   input  logic    rst_n,
   cu_pipe_if.slave bus
);

`ifdef CU_M_EXT_EN
   localparam bit M_EXT = 1'b1;
`else
   localparam bit M_EXT = 1'b0;
`endif

   localparam int PTR_W = $clog2(DEPTH);
   localparam int OCC_W = PTR_W + 1;
   localparam logic [OCC_W-1:0] DEPTH_C = OCC_W'(DEPTH);

   localparam logic [6:0] OP_R      = 7'b0110011;
   localparam logic [6:0] OP_I      = 7'b0010011;
   localparam logic [6:0] OP_LOAD   = 7'b0000011;
   localparam logic [6:0] OP_STORE  = 7'b0100011;
   localparam logic [6:0] OP_JALR   = 7'b1100111;
   localparam logic [6:0] OP_JAL    = 7'b1101111;
   localparam logic [6:0] OP_AUIPC  = 7'b0010111;
   localparam logic [6:0] OP_LUI    = 7'b0110111;
   localparam logic [6:0] OP_BRANCH = 7'b1100011;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;
   localparam logic [6:0] F7_MUL  = 7'b0000001;

   localparam logic [ALUCTRL_W-1:0] ALU_ADD  = ALUCTRL_W'(1);
   localparam logic [ALUCTRL_W-1:0] ALU_SUB  = ALUCTRL_W'(2);
   localparam logic [ALUCTRL_W-1:0] ALU_SLL  = ALUCTRL_W'(3);
   localparam logic [ALUCTRL_W-1:0] ALU_SLT  = ALUCTRL_W'(4);
   localparam logic [ALUCTRL_W-1:0] ALU_SLTU = ALUCTRL_W'(5);
   localparam logic [ALUCTRL_W-1:0] ALU_XOR  = ALUCTRL_W'(6);
   localparam logic [ALUCTRL_W-1:0] ALU_SRL  = ALUCTRL_W'(7);
   localparam logic [ALUCTRL_W-1:0] ALU_SRA  = ALUCTRL_W'(8);
   localparam logic [ALUCTRL_W-1:0] ALU_OR   = ALUCTRL_W'(9);
   localparam logic [ALUCTRL_W-1:0] ALU_AND  = ALUCTRL_W'(10);
   localparam logic [ALUCTRL_W-1:0] ALU_EQU  = ALUCTRL_W'(11);
   localparam logic [ALUCTRL_W-1:0] ALU_NEQ  = ALUCTRL_W'(12);
   localparam logic [ALUCTRL_W-1:0] ALU_SGE  = ALUCTRL_W'(13);
   localparam logic [ALUCTRL_W-1:0] ALU_SGEU = ALUCTRL_W'(14);
   localparam logic [ALUCTRL_W-1:0] ALU_MUL  = ALUCTRL_W'(16);

   typedef struct packed {
      logic [ALUCTRL_W-1:0] alu;
      logic                 branch;
      logic                 jump;
      logic                 mem;
      logic                 illegal;
   } entry_t;

   entry_t                 mem_q [DEPTH];
   entry_t                 mem_d [DEPTH];
   logic [PTR_W-1:0]       wr_ptr_q, wr_ptr_d;
   logic [PTR_W-1:0]       rd_ptr_q, rd_ptr_d;
   logic [OCC_W-1:0]       count_q, count_d;
   logic [CNT_W-1:0]       ill_cnt_q, ill_cnt_d;

   logic [ALUCTRL_W-1:0]   dec_alu;
   logic                   dec_branch, dec_jump, dec_mem, dec_legal;
   entry_t                 dec_entry;
   logic                   id_ready, cu_valid, push, pop;

   // Instruction decode. dec_legal starts high and each unsupported encoding
   // clears it. An illegal result is then forced to NO_OP with all class
   // flags low, so the EX stage never sees a partial decode.
   always_comb begin
      dec_alu    = '0;
      dec_branch = 1'b0;
      dec_jump   = 1'b0;
      dec_mem    = 1'b0;
      dec_legal  = 1'b1;
      case (bus.id_opcode_i)
         OP_R: begin
            if (M_EXT && bus.id_func7_i == F7_MUL) begin
               dec_alu = ALU_MUL + ALUCTRL_W'(bus.id_func3_i);
            end else if (bus.id_func7_i == F7_BASE) begin
               case (bus.id_func3_i)
                  3'd0:    dec_alu = ALU_ADD;
                  3'd1:    dec_alu = ALU_SLL;
                  3'd2:    dec_alu = ALU_SLT;
                  3'd3:    dec_alu = ALU_SLTU;
                  3'd4:    dec_alu = ALU_XOR;
                  3'd5:    dec_alu = ALU_SRL;
                  3'd6:    dec_alu = ALU_OR;
                  default: dec_alu = ALU_AND;
               endcase
            end else if (bus.id_func7_i == F7_ALT && bus.id_func3_i == 3'd0) begin
               dec_alu = ALU_SUB;
            end else if (bus.id_func7_i == F7_ALT && bus.id_func3_i == 3'd5) begin
               dec_alu = ALU_SRA;
            end else begin
               dec_legal = 1'b0;
            end
         end
         OP_I: begin
            // func7 is immediate data for most I-arith ops and only
            // qualifies the shift encodings.
            case (bus.id_func3_i)
               3'd0: dec_alu = ALU_ADD;
               3'd1: begin
                  if (bus.id_func7_i == F7_BASE) dec_alu = ALU_SLL;
                  else                           dec_legal = 1'b0;
               end
               3'd2: dec_alu = ALU_SLT;
               3'd3: dec_alu = ALU_SLTU;
               3'd4: dec_alu = ALU_XOR;
               3'd5: begin
                  if (bus.id_func7_i == F7_BASE)     dec_alu = ALU_SRL;
                  else if (bus.id_func7_i == F7_ALT) dec_alu = ALU_SRA;
                  else                               dec_legal = 1'b0;
               end
               3'd6:    dec_alu = ALU_OR;
               default: dec_alu = ALU_AND;
            endcase
         end
         OP_LOAD, OP_STORE: begin
            dec_alu = ALU_ADD;
            dec_mem = 1'b1;
         end
         OP_JALR, OP_JAL: begin
            dec_alu  = ALU_ADD;
            dec_jump = 1'b1;
         end
         OP_AUIPC, OP_LUI: dec_alu = ALU_ADD;
         OP_BRANCH: begin
            dec_branch = 1'b1;
            case (bus.id_func3_i)
               3'd0:    dec_alu = ALU_EQU;
               3'd1:    dec_alu = ALU_NEQ;
               3'd4:    dec_alu = ALU_SLT;
               3'd5:    dec_alu = ALU_SGE;
               3'd6:    dec_alu = ALU_SLTU;
               3'd7:    dec_alu = ALU_SGEU;
               default: dec_legal = 1'b0;
            endcase
         end
         default: dec_legal = 1'b0;
      endcase

      if (dec_legal) begin
         dec_entry = '{alu: dec_alu, branch: dec_branch, jump: dec_jump,
                       mem: dec_mem, illegal: 1'b0};
      end else begin
         dec_entry = '{alu: '0, branch: 1'b0, jump: 1'b0, mem: 1'b0,
                       illegal: 1'b1};
      end
   end

   // Handshake and FIFO next state. ready depends only on the registered
   // occupancy, so there is no combinational path from ex_ready_i. A flush
   // overrides both push and pop and rewinds the pointers. The illegal counter
   // survives the flush and counts only instructions that were accepted.
   always_comb begin
      id_ready = (count_q < DEPTH_C);
      cu_valid = (count_q != '0);
      push     = bus.id_valid_i && id_ready && !bus.ex_flush_i;
      pop      = cu_valid && bus.ex_ready_i && !bus.ex_flush_i;

      mem_d     = mem_q;
      wr_ptr_d  = wr_ptr_q;
      rd_ptr_d  = rd_ptr_q;
      count_d   = count_q;
      ill_cnt_d = ill_cnt_q;

      if (push) begin
         mem_d[wr_ptr_q] = dec_entry;
         wr_ptr_d        = wr_ptr_q + PTR_W'(1);
         if (dec_entry.illegal && ill_cnt_q != '1) begin
            ill_cnt_d = ill_cnt_q + CNT_W'(1);
         end
      end
      if (pop) begin
         rd_ptr_d = rd_ptr_q + PTR_W'(1);
      end
      case ({push, pop})
         2'b10:   count_d = count_q + OCC_W'(1);
         2'b01:   count_d = count_q - OCC_W'(1);
         default: count_d = count_q;
      endcase

      if (bus.ex_flush_i) begin
         wr_ptr_d = '0;
         rd_ptr_d = '0;
         count_d  = '0;
      end
   end

   // State registers. The reset is asynchronous, so all of this state clears
   // as soon as rst_n falls.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= '0;
         end
         wr_ptr_q  <= '0;
         rd_ptr_q  <= '0;
         count_q   <= '0;
         ill_cnt_q <= '0;
      end else begin
         mem_q     <= mem_d;
         wr_ptr_q  <= wr_ptr_d;
         rd_ptr_q  <= rd_ptr_d;
         count_q   <= count_d;
         ill_cnt_q <= ill_cnt_d;
      end
   end

   assign bus.id_ready_o       = id_ready;
   assign bus.cu_valid_o       = cu_valid;
   assign bus.cu_ALUctrl_o     = mem_q[rd_ptr_q].alu;
   assign bus.cu_branch_o      = mem_q[rd_ptr_q].branch;
   assign bus.cu_jump_o        = mem_q[rd_ptr_q].jump;
   assign bus.cu_mem_o         = mem_q[rd_ptr_q].mem;
   assign bus.cu_illegal_o     = mem_q[rd_ptr_q].illegal;
   assign bus.cu_illegal_cnt_o = ill_cnt_q;

endmodule

// File: tb/tb_cu_pipe.sv
// -----------------------------------------------------------------------------
// tb_cu_pipe
// Scoreboard bench for cu_pipe (DEPTH=2, CNT_W=2). The stimulus side pushes
// the expected decode of every accepted instruction into a queue. A negedge
// monitor compares the DUT head, ready and counter against that model and pops
// an entry whenever EX takes one.
// -----------------------------------------------------------------------------
module tb_cu_pipe;
   localparam int ALUCTRL_W = 5;
   localparam int DEPTH     = 2;
   localparam int CNT_W     = 2;
   localparam int CNT_MAX   = (1 << CNT_W) - 1;

   // ALU codes by func3, straight from the ISA tables.
   localparam int ARITH_TAB [8] = '{1, 3, 4, 5, 6, 7, 9, 10};
   localparam int BR_TAB    [8] = '{11, 12, 0, 0, 4, 13, 5, 14};
   localparam logic [6:0] OPS [10] = '{7'h33, 7'h13, 7'h03, 7'h23, 7'h67,
                                       7'h6F, 7'h17, 7'h37, 7'h63, 7'h7F};

   typedef struct {
      int alu;
      bit br;
      bit jmp;
      bit mem;
      bit ill;
   } exp_t;

   logic clk;
   logic rst_n;
   exp_t exp_q [$];
   int   model_cnt;
   int   checks;
   int   errors;
   bit   popped;
   bit   mon_en;

   cu_pipe_if #(.ALUCTRL_W(ALUCTRL_W), .CNT_W(CNT_W)) bus ();

   cu_pipe #(.ALUCTRL_W(ALUCTRL_W), .DEPTH(DEPTH), .CNT_W(CNT_W)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   // Free-running 10-unit clock.
   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   function automatic exp_t mk(int alu, bit br, bit jmp, bit mem);
      exp_t e;
      e = '{alu: alu, br: br, jmp: jmp, mem: mem, ill: 1'b0};
      return e;
   endfunction

   // Reference decode, written from the ISA rules. Anything that no rule
   // matches stays illegal.
   function automatic exp_t ref_decode(logic [6:0] op, logic [2:0] f3, logic [6:0] f7);
      exp_t e;
      e = '{alu: 0, br: 1'b0, jmp: 1'b0, mem: 1'b0, ill: 1'b1};
      case (op)
         7'h33: begin
            if (f7 == 7'h00) e = mk(ARITH_TAB[f3], 0, 0, 0);
            if (f7 == 7'h20 && f3 == 3'd0) e = mk(2, 0, 0, 0);
            if (f7 == 7'h20 && f3 == 3'd5) e = mk(8, 0, 0, 0);
`ifdef CU_M_EXT_EN
            if (f7 == 7'h01) e = mk(16 + int'(f3), 0, 0, 0);
`endif
         end
         7'h13: begin
            if (f3 == 3'd1) begin
               if (f7 == 7'h00) e = mk(3, 0, 0, 0);
            end else if (f3 == 3'd5) begin
               if (f7 == 7'h00) e = mk(7, 0, 0, 0);
               if (f7 == 7'h20) e = mk(8, 0, 0, 0);
            end else begin
               e = mk(ARITH_TAB[f3], 0, 0, 0);
            end
         end
         7'h03, 7'h23: e = mk(1, 0, 0, 1);
         7'h67, 7'h6F: e = mk(1, 0, 1, 0);
         7'h17, 7'h37: e = mk(1, 0, 0, 0);
         7'h63: if (f3 != 3'd2 && f3 != 3'd3) e = mk(BR_TAB[f3], 1, 0, 0);
         default: ;
      endcase
      return e;
   endfunction

   task automatic checkOutput(string name, int act, int expv);
      checks++;
      if (act != expv) begin
         errors++;
         $display("[TB] FAIL %s at %0t: got %0d, expected %0d", name, $time, act, expv);
      end
   endtask

   // Monitor: once per cycle, away from the active edge, compare the DUT
   // against the model and retire the head when EX takes it.
   always @(negedge clk) begin
      popped = 1'b0;
      if (mon_en && rst_n) begin
         checkOutput("id_ready", int'(bus.id_ready_o), int'(exp_q.size() < DEPTH));
         checkOutput("illegal_cnt", int'(bus.cu_illegal_cnt_o), model_cnt);
         checkOutput("cu_valid", int'(bus.cu_valid_o), int'(exp_q.size() != 0));
         if (exp_q.size() != 0) begin
            checkOutput("alu", int'(bus.cu_ALUctrl_o), exp_q[0].alu);
            checkOutput("branch", int'(bus.cu_branch_o), int'(exp_q[0].br));
            checkOutput("jump", int'(bus.cu_jump_o), int'(exp_q[0].jmp));
            checkOutput("mem", int'(bus.cu_mem_o), int'(exp_q[0].mem));
            checkOutput("illegal", int'(bus.cu_illegal_o), int'(exp_q[0].ill));
            if (bus.ex_ready_i && !bus.ex_flush_i) begin
               void'(exp_q.pop_front());
               popped = 1'b1;
            end
         end
      end
   end

   // Called at each active edge. The inputs driven for the previous cycle
   // take effect here, so the model applies any flush or accept for them,
   // and then the next cycle's inputs are driven.
   task automatic applyStimulus(bit v, logic [6:0] op, logic [2:0] f3,
                                logic [6:0] f7, bit rdy, bit fl);
      int   occ;
      exp_t e;
      @(posedge clk);
      occ = exp_q.size() + int'(popped);
      if (bus.ex_flush_i) begin
         exp_q.delete();
      end else if (bus.id_valid_i && occ < DEPTH) begin
         e = ref_decode(bus.id_opcode_i, bus.id_func3_i, bus.id_func7_i);
         exp_q.push_back(e);
         if (e.ill && model_cnt < CNT_MAX) model_cnt++;
      end
      #1;
      bus.id_valid_i  = v;
      bus.id_opcode_i = op;
      bus.id_func3_i  = f3;
      bus.id_func7_i  = f7;
      bus.ex_ready_i  = rdy;
      bus.ex_flush_i  = fl;
   endtask

   task automatic idleInputs();
      bus.id_valid_i  = 1'b0;
      bus.id_opcode_i = '0;
      bus.id_func3_i  = '0;
      bus.id_func7_i  = '0;
      bus.ex_ready_i  = 1'b0;
      bus.ex_flush_i  = 1'b0;
   endtask

   // Assert reset asynchronously, clear the model, check the reset values
   // while reset is still low, then release reset away from the clock edge.
   task automatic doReset();
      rst_n = 1'b0;
      idleInputs();
      exp_q.delete();
      model_cnt = 0;
      repeat (2) @(negedge clk);
      checkOutput("reset cu_valid", int'(bus.cu_valid_o), 0);
      checkOutput("reset illegal_cnt", int'(bus.cu_illegal_cnt_o), 0);
      checkOutput("reset id_ready", int'(bus.id_ready_o), 1);
      checkOutput("reset alu", int'(bus.cu_ALUctrl_o), 0);
      @(posedge clk);
      #2 rst_n = 1'b1;
   endtask

   task automatic randomCycles(int n);
      logic [6:0] op;
      logic [6:0] f7;
      for (int i = 0; i < n; i++) begin
         op = ($urandom_range(0, 7) == 0) ? 7'($urandom) : OPS[$urandom_range(0, 9)];
         case ($urandom_range(0, 3))
            0:       f7 = 7'h00;
            1:       f7 = 7'h20;
            2:       f7 = 7'h01;
            default: f7 = 7'($urandom);
         endcase
         applyStimulus($urandom_range(0, 9) < 7, op, 3'($urandom), f7,
                       $urandom_range(0, 9) < 6, $urandom_range(0, 19) == 0);
      end
   endtask

   initial begin
      checks    = 0;
      errors    = 0;
      model_cnt = 0;
      popped    = 1'b0;
      mon_en    = 1'b1;
      idleInputs();
      doReset();

      // SUB right after reset, visible on the next cycle.
      applyStimulus(1, 7'h33, 3'd0, 7'h20, 1, 0);
      applyStimulus(0, 7'h00, 3'd0, 7'h00, 1, 0);
      applyStimulus(0, 7'h00, 3'd0, 7'h00, 1, 0);

      // Back-pressure: three pushes into a 2-deep FIFO, then drain.
      applyStimulus(1, 7'h33, 3'd4, 7'h00, 0, 0);
      applyStimulus(1, 7'h13, 3'd3, 7'h00, 0, 0);
      applyStimulus(1, 7'h63, 3'd7, 7'h00, 0, 0);
      applyStimulus(1, 7'h63, 3'd7, 7'h00, 0, 0);
      applyStimulus(1, 7'h63, 3'd7, 7'h00, 0, 0);
      applyStimulus(0, 7'h00, 3'd0, 7'h00, 1, 0);
      repeat (3) applyStimulus(0, 7'h00, 3'd0, 7'h00, 1, 0);

      // Branch cases, I-arith cases, illegal shifts.
      applyStimulus(1, 7'h63, 3'd7, 7'h00, 1, 0);
      applyStimulus(1, 7'h63, 3'd2, 7'h00, 1, 0);
      applyStimulus(1, 7'h13, 3'd3, 7'h55, 1, 0);
      applyStimulus(1, 7'h13, 3'd5, 7'h20, 1, 0);
      applyStimulus(1, 7'h13, 3'd1, 7'h20, 1, 0);
      applyStimulus(1, 7'h33, 3'd4, 7'h01, 1, 0);
      applyStimulus(0, 7'h00, 3'd0, 7'h00, 1, 0);
      repeat (2) applyStimulus(0, 7'h00, 3'd0, 7'h00, 1, 0);

      // Flush with two entries queued and an illegal instruction offered.
      applyStimulus(1, 7'h03, 3'd2, 7'h00, 0, 0);
      applyStimulus(1, 7'h6F, 3'd0, 7'h00, 0, 0);
      applyStimulus(1, 7'h7F, 3'd0, 7'h00, 0, 1);
      repeat (2) applyStimulus(0, 7'h00, 3'd0, 7'h00, 1, 0);

      // Counter saturation from a fresh reset.
      doReset();
      repeat (5) applyStimulus(1, 7'h7F, 3'd0, 7'h00, 1, 0);
      repeat (2) applyStimulus(0, 7'h00, 3'd0, 7'h00, 1, 0);

      // Random traffic with a reset in the middle.
      randomCycles(1500);
      doReset();
      randomCycles(1500);
      repeat (4) applyStimulus(0, 7'h00, 3'd0, 7'h00, 1, 0);
      @(negedge clk);
      mon_en = 1'b0;

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/cu_pipe.md
Name: cu_pipe

Overview:
Parametrised, pipelined successor to the combinational ALU-control decoder.
- Decodes the RV32I opcode, func3 and func7 fields into an ALU control code plus class flags, and flags illegal encodings.
- Queues decoded results in a DEPTH-entry FIFO between ID and the ID/EX stage, under a valid/ready handshake.
- Supports flush and keeps a saturating count of illegal instructions.

Parameters:
- ALUCTRL_W, 5, width of the ALU control code (minimum 5).
- DEPTH, 2, number of decode FIFO entries; power of two, at least 2.
- CNT_W, 8, width of the illegal-instruction counter.

Ports:
- clk  in  1  clock.
- rst_n  in  1  asynchronous active-low reset.
- id_valid_i  in  1  ID presents an instruction.
- id_ready_o  out  1  CU can accept an instruction.
- id_opcode_i  in  7  instruction bits [6:0].
- id_func3_i  in  3  instruction bits [14:12].
- id_func7_i  in  7  instruction bits [31:25].
- ex_ready_i  in  1  ID/EX register accepts the head entry.
- ex_flush_i  in  1  discard all queued and incoming entries.
- cu_valid_o  out  1  head entry is valid.
- cu_ALUctrl_o  out  ALUCTRL_W  ALU code of the head entry.
- cu_branch_o  out  1  head entry is a B-type instruction.
- cu_jump_o  out  1  head entry is JAL or JALR.
- cu_mem_o  out  1  head entry is a load or store.
- cu_illegal_o  out  1  head entry is an illegal encoding.
- cu_illegal_cnt_o  out  CNT_W  saturating count of illegal instructions accepted.

Behaviour:
- Clock and reset: one clock. Reset is asynchronous, active-low.
- Values on reset: count=0, read/write pointers=0, every output register 0, cu_valid_o=0, cu_illegal_cnt_o=0.
- ALU codes (zero-extended to ALUCTRL_W): NO_OP=0, ADD=1, SUB=2, SLL=3, SLT=4, SLTU=5, XOR=6, SRL=7, SRA=8, OR=9, AND=10, EQU=11, NEQ=12, SGE=13, SGEU=14.
- Decode by opcode:
  - R (0110011):
    - func3 0: func7 0000000 gives ADD, 0100000 gives SUB.
    - func3 1/2/3/4: SLL/SLT/SLTU/XOR.
    - func3 5: func7 0000000 gives SRL, 0100000 gives SRA.
    - func3 6/7: OR/AND.
    - Any other func7 is illegal; the only exception is under M_EXT_EN.
  - I-arith (0010011):
    - func3 0/2/3/4/6/7: ADD/SLT/SLTU/XOR/OR/AND.
    - func3 1: SLL, only when func7=0000000.
    - func3 5: func7 0000000 gives SRL, 0100000 gives SRA.
    - Any other func7 is illegal.
  - Load (0000011), store (0100011), JALR (1100111), JAL (1101111), AUIPC (0010111): ADD. LUI (0110111): ADD.
  - B-type (1100011): func3 0/1/4/5/6/7 give EQU/NEQ/SLT/SGE/SLTU/SGEU. func3 2 and 3 are illegal.
  - Any other opcode is illegal.
- Illegal entries carry ALU code NO_OP and all class flags 0.
- Handshake:
  - An instruction is accepted when id_valid_i && id_ready_o.
  - The head entry is popped when cu_valid_o && ex_ready_i.
  - id_ready_o = (count < DEPTH). It is registered-derived, with no combinational path from ex_ready_i.
- Latency: an accepted instruction appears on the cu_* outputs in the next cycle when the FIFO was empty. Otherwise it appears after the entries ahead of it are popped.
- Simultaneous push and pop while full is not allowed, because id_ready_o is 0. A push and pop in the same cycle when 0<count<DEPTH leaves count unchanged.
- Pointers wrap modulo DEPTH.
- Outputs are held stable while cu_valid_o && !ex_ready_i.
- Flush: ex_flush_i=1 takes priority over push and pop. Next cycle: count=0, cu_valid_o=0. An instruction presented in the same cycle is dropped and is not counted.
- cu_illegal_cnt_o increments by 1 on each accepted illegal instruction. It saturates at 2^CNT_W-1 and is not cleared by flush.
- Reset asserted mid-operation clears all state immediately.

Optional Feature:
Macro CU_M_EXT_EN.
- Defined: R-type with func7=0000001 decodes as RV32M. func3 0..7 give MUL=16, MULH=17, MULHSU=18, MULHU=19, DIV=20, DIVU=21, REM=22, REMU=23.
- Undefined: those encodings are illegal.

Test Plan:
1. After reset: id_valid_i=1, opcode 0110011, func3 0, func7 0100000, ex_ready_i=1 -> next cycle cu_valid_o=1, cu_ALUctrl_o=2, cu_illegal_o=0.
2. Back-pressure: ex_ready_i=0, push 3 instructions with DEPTH=2 -> id_ready_o=0 after 2 accepts. The third is held. Head stays stable. Raising ex_ready_i drains in order.
3. Branch: opcode 1100011, func3 7 -> cu_ALUctrl_o=14, cu_branch_o=1. func3 2 -> cu_illegal_o=1, cu_ALUctrl_o=0, cu_illegal_cnt_o incremented.
4. I-arith: func3 3 (SLTIU) -> cu_ALUctrl_o=5. func3 5, func7 0100000 -> 8. func3 1, func7 0100000 -> illegal.
5. Flush: with 2 entries queued, assert ex_flush_i together with id_valid_i -> next cycle cu_valid_o=0, id_ready_o=1, counter unchanged.
6. Saturation with CNT_W=2: 5 illegal opcodes 1111111 -> cu_illegal_cnt_o=3. With CU_M_EXT_EN, func7 0000001 func3 4 -> 20. Without the macro, the same input is illegal.
